// File: rtl/activation_pkg.sv
// activation_pkg: shared definitions for the sequential activation layer.
// Holds the activation mode encodings, the FSM state type and the
// piecewise-linear tanh breakpoints/offsets as functions of the fraction width.
package activation_pkg;

    // Activation mode encodings (value of the 2-bit mode input)
    localparam logic [1:0] ACT_IDENT   = 2'd0;
    localparam logic [1:0] ACT_RELU    = 2'd1;
    localparam logic [1:0] ACT_HTANH   = 2'd2;
    localparam logic [1:0] ACT_PWLTANH = 2'd3;

    // FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // 1.0 in fixed point
    function automatic longint pwl_one(input int unsigned fb);
        return longint'(1) << fb;
    endfunction

    // 0.5 breakpoint
    function automatic longint pwl_half(input int unsigned fb);
        return longint'(1) << (fb - 1);
    endfunction

    // 2.0 breakpoint
    function automatic longint pwl_two(input int unsigned fb);
        return longint'(2) << fb;
    endfunction

    // 3.0 breakpoint (saturation point)
    function automatic longint pwl_three(input int unsigned fb);
        return longint'(3) << fb;
    endfunction

    // 0.375 offset for the middle segment
    function automatic longint pwl_off_lo(input int unsigned fb);
        return longint'(3) << (fb - 3);
    endfunction

    // 0.625 offset for the upper segment
    function automatic longint pwl_off_hi(input int unsigned fb);
        return longint'(5) << (fb - 3);
    endfunction

    // Largest positive value representable in dw bits
    function automatic longint max_pos(input int unsigned dw);
        return (longint'(1) << (dw - 1)) - longint'(1);
    endfunction

endpackage

// File: rtl/act_lane_pwl.sv
// act_lane_pwl: combinational single-neuron activation.
// Ports:
//   mode : activation select (identity, ReLU, hard-tanh, PWL tanh)
//   x    : signed fixed-point input neuron
//   y_c  : activated output, same format as x
module act_lane_pwl
    import activation_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FracBits  = 16
) (
    input  logic [1:0]                  mode,
    input  logic signed [DataWidth-1:0] x,
    output logic signed [DataWidth-1:0] y_c
);

    // One guard bit so |x| of the most negative input is representable
    localparam int unsigned W = DataWidth + 1;

    localparam logic signed [W-1:0] ONE     = W'(pwl_one(FracBits));
    localparam logic signed [W-1:0] HALF    = W'(pwl_half(FracBits));
    localparam logic signed [W-1:0] TWO     = W'(pwl_two(FracBits));
    localparam logic signed [W-1:0] THREE   = W'(pwl_three(FracBits));
    localparam logic signed [W-1:0] OFF_LO  = W'(pwl_off_lo(FracBits));
    localparam logic signed [W-1:0] OFF_HI  = W'(pwl_off_hi(FracBits));
    localparam logic signed [W-1:0] MAX_POS = W'(max_pos(DataWidth));

    logic signed [W-1:0] xe;
    logic signed [W-1:0] a;
    logic signed [W-1:0] m;

    // PWL tanh magnitude: saturated |x| folded through three linear segments
    always_comb begin
        xe = {x[DataWidth-1], x};
        a  = x[DataWidth-1] ? -xe : xe;
        if (a > MAX_POS) begin
            a = MAX_POS;
        end
        if (a < HALF) begin
            m = a;
        end else if (a < TWO) begin
            m = (a >> 2) + OFF_LO;
        end else if (a < THREE) begin
            m = (a >> 3) + OFF_HI;
        end else begin
            m = ONE;
        end
    end

    // Output select
    always_comb begin
        y_c = x;
        case (mode)
            ACT_IDENT: y_c = x;
            ACT_RELU:  y_c = x[DataWidth-1] ? '0 : x;
            ACT_HTANH: begin
                if (xe > ONE) begin
                    y_c = DataWidth'(ONE);
                end else if (xe < -ONE) begin
                    y_c = DataWidth'(-ONE);
                end else begin
                    y_c = x;
                end
            end
            ACT_PWLTANH: y_c = x[DataWidth-1] ? DataWidth'(-m) : DataWidth'(m);
            default:     y_c = x;
        endcase
    end

endmodule

// File: rtl/activation_layer_seq.sv
// activation_layer_seq: time-multiplexed activation stage for a neuron vector.
// Captures Neurons/mode on start, then processes LANES neurons per cycle.
// Ports:
//   clk, reset       : clock (rising edge), async active-high reset
//   start            : capture request, honoured only when idle
//   mode             : activation select, sampled with start
//   Neurons          : packed input vector, neuron i at [i*DataWidth +: DataWidth]
//   busy             : high while groups are being processed
//   done             : one-cycle pulse when the last group is written
//   finished         : high while ActivatedNeurons holds a complete result
//   ActivatedNeurons : registered results, same packing as Neurons
module activation_layer_seq
    import activation_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned FracBits      = 16,
    parameter int unsigned No_of_Neurons = 24,
    parameter int unsigned LANES         = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [1:0]                           mode,
    input  logic [DataWidth*No_of_Neurons-1:0]   Neurons,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 finished,
    output logic [DataWidth*No_of_Neurons-1:0]   ActivatedNeurons
);

    localparam int unsigned G  = (No_of_Neurons + LANES - 1) / LANES;
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
    // Candidate table per lane covers every group_q encoding
    localparam int unsigned GS = 1 << GW;

    state_t         state_q;
    state_t         state_d;
    logic [GW-1:0]  group_q;
    logic [GW-1:0]  group_d;
    logic [1:0]     mode_q;
    logic           busy_d;
    logic           done_d;
    logic           finished_d;
    logic           capture;
    logic           wr_en;

    logic [DataWidth-1:0] in_buf_q [No_of_Neurons];
    logic [DataWidth-1:0] out_q    [No_of_Neurons];
    logic [DataWidth-1:0] lane_x   [LANES];
    logic [DataWidth-1:0] lane_y   [LANES];

    // Lane input mux and activators; lanes past the last neuron see zero
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DataWidth-1:0] cand [GS];
        for (genvar g = 0; g < GS; g++) begin : g_cand
            if (g * LANES + l < No_of_Neurons) begin : g_valid
                assign cand[g] = in_buf_q[g*LANES+l];
            end else begin : g_pad
                assign cand[g] = '0;
            end
        end
        assign lane_x[l] = cand[group_q];

        act_lane_pwl #(
            .DataWidth (DataWidth),
            .FracBits  (FracBits)
        ) u_lane (
            .mode (mode_q),
            .x    (lane_x[l]),
            .y_c  (lane_y[l])
        );
    end

    // Next-state and control decode
    always_comb begin
        state_d    = state_q;
        group_d    = group_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        finished_d = finished;
        capture    = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    finished_d = 1'b0;
                    group_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_en = 1'b1;
                if (group_q == GW'(G - 1)) begin
                    done_d     = 1'b1;
                    finished_d = 1'b1;
                    group_d    = '0;
                    state_d    = ST_IDLE;
                end else begin
                    group_d = group_q + GW'(1);
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                group_d = '0;
            end
        endcase
    end

    // State, control outputs, input capture and grouped result writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            group_q  <= '0;
            mode_q   <= ACT_IDENT;
            busy     <= 1'b0;
            done     <= 1'b0;
            finished <= 1'b0;
            for (int n = 0; n < No_of_Neurons; n++) begin
                in_buf_q[n] <= '0;
                out_q[n]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            group_q  <= group_d;
            busy     <= busy_d;
            done     <= done_d;
            finished <= finished_d;
            if (capture) begin
                mode_q <= mode;
                for (int n = 0; n < No_of_Neurons; n++) begin
                    in_buf_q[n] <= Neurons[n*DataWidth +: DataWidth];
                end
            end
            // Slot n belongs to group n/LANES, lane n%LANES
            for (int n = 0; n < No_of_Neurons; n++) begin
                if (wr_en && (group_q == GW'(n / LANES))) begin
                    out_q[n] <= lane_y[n % LANES];
                end
            end
        end
    end

    for (genvar n = 0; n < No_of_Neurons; n++) begin : g_pack
        assign ActivatedNeurons[n*DataWidth +: DataWidth] = out_q[n];
    end

endmodule

// File: tb/tb_activation_layer_seq.sv
// tb_activation_layer_seq: directed table-driven bench for activation_layer_seq
// (DataWidth=16, FracBits=8, N=6, LANES=4) plus a LANES=N instance.
module tb_activation_layer_seq;
    import activation_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned FB = 8;
    localparam int unsigned NN = 6;
    localparam int unsigned VW = DW * NN;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [VW-1:0] neurons;
    logic          busy;
    logic          done;
    logic          finished;
    logic [VW-1:0] act;

    logic          start6;
    logic [1:0]    mode6;
    logic [VW-1:0] neurons6;
    logic          busy6;
    logic          done6;
    logic          finished6;
    logic [VW-1:0] act6;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    activation_layer_seq #(
        .DataWidth(DW), .FracBits(FB), .No_of_Neurons(NN), .LANES(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .Neurons(neurons),
        .busy(busy), .done(done), .finished(finished), .ActivatedNeurons(act)
    );

    activation_layer_seq #(
        .DataWidth(DW), .FracBits(FB), .No_of_Neurons(NN), .LANES(6)
    ) dut6 (
        .clk(clk), .reset(reset), .start(start6), .mode(mode6), .Neurons(neurons6),
        .busy(busy6), .done(done6), .finished(finished6), .ActivatedNeurons(act6)
    );

    typedef struct packed {
        logic [1:0]    mode;
        logic [VW-1:0] din;
        logic [VW-1:0] dout;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [VW-1:0] pack6(input logic [15:0] v0, v1, v2, v3, v4, v5);
        return {v5, v4, v3, v2, v1, v0};
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full run with per-cycle handshake checks
    task automatic run_vec(input int i);
        start   = 1'b1;
        mode    = vecs[i].mode;
        neurons = vecs[i].din;
        step();
        start = 1'b0;
        chk($sformatf("v%0d_busy_e0", i), VW'(busy), VW'(1));
        chk($sformatf("v%0d_fin_e0", i), VW'(finished), VW'(0));
        chk($sformatf("v%0d_done_e0", i), VW'(done), VW'(0));
        step();
        chk($sformatf("v%0d_busy_e1", i), VW'(busy), VW'(1));
        chk($sformatf("v%0d_done_e1", i), VW'(done), VW'(0));
        step();
        chk($sformatf("v%0d_done_e2", i), VW'(done), VW'(1));
        chk($sformatf("v%0d_fin_e2", i), VW'(finished), VW'(1));
        chk($sformatf("v%0d_busy_e2", i), VW'(busy), VW'(0));
        chk($sformatf("v%0d_out", i), act, vecs[i].dout);
        step();
        chk($sformatf("v%0d_done_e3", i), VW'(done), VW'(0));
        chk($sformatf("v%0d_fin_e3", i), VW'(finished), VW'(1));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'd0;
        neurons  = '0;
        start6   = 1'b0;
        mode6    = 2'd0;
        neurons6 = '0;

        vecs[0] = '{ACT_PWLTANH,
            pack6(16'h0080, 16'h0100, 16'hFF00, 16'h0280, 16'h0400, 16'h8000),
            pack6(16'h0080, 16'h00A0, 16'hFF60, 16'h00F0, 16'h0100, 16'hFF00)};
        vecs[1] = '{ACT_RELU,
            pack6(16'h0080, 16'h0100, 16'hFF00, 16'h0280, 16'h0400, 16'h8000),
            pack6(16'h0080, 16'h0100, 16'h0000, 16'h0280, 16'h0400, 16'h0000)};
        vecs[2] = '{ACT_HTANH,
            pack6(16'h0080, 16'h0100, 16'hFF00, 16'h0280, 16'h0400, 16'h8000),
            pack6(16'h0080, 16'h0100, 16'hFF00, 16'h0100, 16'h0100, 16'hFF00)};
        vecs[3] = '{ACT_IDENT,
            pack6(16'h0080, 16'h0100, 16'hFF00, 16'h0280, 16'h0400, 16'h8000),
            pack6(16'h0080, 16'h0100, 16'hFF00, 16'h0280, 16'h0400, 16'h8000)};
        vecs[4] = '{ACT_PWLTANH,
            pack6(16'h0040, 16'hFF80, 16'h01FF, 16'h0200, 16'h02FF, 16'h0300),
            pack6(16'h0040, 16'hFF80, 16'h00DF, 16'h00E0, 16'h00FF, 16'h0100)};
        vecs[5] = '{ACT_PWLTANH,
            pack6(16'hFE00, 16'h7FFF, 16'hFFFF, 16'h0000, 16'hFD00, 16'hFC01),
            pack6(16'hFF20, 16'h0100, 16'hFFFF, 16'h0000, 16'hFF00, 16'hFF00)};
        vecs[6] = '{ACT_HTANH,
            pack6(16'h0101, 16'hFEFF, 16'h00FF, 16'hFF01, 16'h7FFF, 16'h8001),
            pack6(16'h0100, 16'hFF00, 16'h00FF, 16'hFF01, 16'h0100, 16'hFF00)};
        vecs[7] = '{ACT_RELU,
            pack6(16'h7FFF, 16'hFFFF, 16'h0001, 16'h8000, 16'h0000, 16'hFF00),
            pack6(16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000)};

        // Reset state
        step();
        step();
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_done", VW'(done), VW'(0));
        chk("rst_fin", VW'(finished), VW'(0));
        chk("rst_out", act, '0);
        reset = 1'b0;
        step();

        // Reset one cycle after start aborts the run
        start   = 1'b1;
        mode    = vecs[1].mode;
        neurons = vecs[1].din;
        step();
        start = 1'b0;
        step();
        chk("abort_g0_written", act, {32'h0, vecs[1].dout[63:0]});
        reset = 1'b1;
        #1;
        chk("abort_out_async", act, '0);
        chk("abort_busy_async", VW'(busy), VW'(0));
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abort_done_c%0d", k), VW'(done), VW'(0));
            chk($sformatf("abort_fin_c%0d", k), VW'(finished), VW'(0));
        end
        reset = 1'b0;
        step();
        chk("abort_idle", VW'(busy), VW'(0));
        run_vec(1);

        // Table-driven runs
        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // start held during RUN with different data is ignored
        start   = 1'b1;
        mode    = vecs[0].mode;
        neurons = vecs[0].din;
        step();
        mode    = ACT_IDENT;
        neurons = vecs[4].din;
        step();
        step();
        start = 1'b0;
        chk("ign_done", VW'(done), VW'(1));
        chk("ign_out", act, vecs[0].dout);
        step();
        chk("ign_no_restart", VW'(busy), VW'(0));
        chk("ign_fin", VW'(finished), VW'(1));

        // Back-to-back: second start on the done cycle
        start   = 1'b1;
        mode    = vecs[1].mode;
        neurons = vecs[1].din;
        step();
        start = 1'b0;
        step();
        step();
        chk("b2b_a_done", VW'(done), VW'(1));
        chk("b2b_a_out", act, vecs[1].dout);
        start   = 1'b1;
        mode    = vecs[2].mode;
        neurons = vecs[2].din;
        step();
        start = 1'b0;
        chk("b2b_fin_low0", VW'(finished), VW'(0));
        chk("b2b_busy", VW'(busy), VW'(1));
        chk("b2b_done_low", VW'(done), VW'(0));
        chk("b2b_hold", act, vecs[1].dout);
        step();
        chk("b2b_fin_low1", VW'(finished), VW'(0));
        chk("b2b_partial", act, {vecs[1].dout[95:64], vecs[2].dout[63:0]});
        step();
        chk("b2b_b_done", VW'(done), VW'(1));
        chk("b2b_b_fin", VW'(finished), VW'(1));
        chk("b2b_b_out", act, vecs[2].dout);

        // LANES == N: single group
        start6   = 1'b1;
        mode6    = ACT_IDENT;
        neurons6 = vecs[5].din;
        step();
        start6 = 1'b0;
        chk("l6_busy", VW'(busy6), VW'(1));
        chk("l6_done_e0", VW'(done6), VW'(0));
        step();
        chk("l6_done", VW'(done6), VW'(1));
        chk("l6_fin", VW'(finished6), VW'(1));
        chk("l6_busy_low", VW'(busy6), VW'(0));
        chk("l6_out", act6, vecs[5].din);
        step();
        chk("l6_done_fall", VW'(done6), VW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
